datapath_seq: RTL and testbench
===============================

Name: datapath_seq

Overview:
- Parametrised successor to the lab datapath: register file, A/B/C operand registers, shifter, ALU and status flags, generalised in data width, register count and PC width.
- Adds an internal micro-sequencer with a valid/ready request port, so a controller issues one whole instruction instead of driving loada/loadb/loadc/write each cycle.
- Sits between the instruction decoder/FSM and memory interface of the CPU.

Parameters:
- DATA_W, 16, datapath and register width (≥8)
- NREGS, 8, number of general registers (power of 2, ≥2)
- PC_W, 9, program-counter width (≤DATA_W)
- IMM5_W, 5, short immediate width before sign extension
- IMM8_W, 8, long immediate width before sign extension

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, accepts request this cycle
- req_rn  in  log2(NREGS)  A-operand register
- req_rm  in  log2(NREGS)  B-operand register
- req_rd  in  log2(NREGS)  destination register
- req_aluop  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B)
- req_shift  in  2  00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B register)
- req_asel  in  1  1: Ain = 0
- req_bsel  in  1  1: Bin = sext(imm5), shifter bypassed
- req_vsel  in  2  writeback source: 00 mdata, 01 sext(imm8), 10 zext(pc), 11 ALU result
- req_wen  in  1  write destination register
- req_loads  in  1  update status flags
- req_imm5  in  IMM5_W  short immediate
- req_imm8  in  IMM8_W  long immediate
- mdata  in  DATA_W  memory read data, sampled at accept
- pc  in  PC_W  program counter, sampled at accept
- done  out  1  one-cycle pulse, instruction completing
- result  out  DATA_W  C register (last ALU result)
- flags  out  3  {Z, N, V}
- dbg_rnum  in  log2(NREGS)  debug read address
- dbg_rdata  out  DATA_W  combinational read of register dbg_rnum

Behaviour:
- Reset (async, rst_n=0): all registers, A, B, C, flags = 0; state IDLE; done = 0; req_ready = 1 after deassert.
- Accept: on rising edge with req_valid && req_ready. All req_* fields, mdata and pc are latched. req_ready = 1 only in IDLE.
- States: IDLE, RDA, RDB, EXE, WB.
- Transitions:
  - IDLE → RDA on accept when vsel == 11; else IDLE → WB.
  - RDA: A ← R[rn]; → RDB.
  - RDB: B ← R[rm]; → EXE.
  - EXE: C ← ALU; if loads, flags ← {Z,N,V}; → WB.
  - WB: done = 1; if wen, R[rd] ← source selected by vsel at the edge ending WB; → IDLE.
- Latency: ALU instruction holds req_ready low for 4 cycles and asserts done in the 4th. Non-ALU writeback asserts done 1 cycle after accept.
- ALU, all DATA_W bits modulo 2^DATA_W:
  - ADD: A+B. SUB: A−B.
  - V (ADD): sign(A)==sign(B) && sign(res)!=sign(A). V (SUB): sign(A)!=sign(B) && sign(res)!=sign(A). V = 0 for AND/MVN.
  - Z = (res == 0). N = res[MSB].
- Shifts are by one bit. ASR replicates the MSB.
- Flags and C hold when not loaded. Non-ALU instructions never touch A, B, C or flags.
- wen = 0: full sequence runs, done still pulses, no register write.
- dbg_rdata during the WB write cycle returns the old value; the new value is visible from the next cycle. No bypass.
- rd == rn/rm: operands read before writeback, so the old value is used.
- Reset mid-sequence aborts immediately with no partial write; done does not pulse.
- X on req_* while req_valid = 0 is ignored.

Decomposition:
- Package dp_pkg: aluop_e, shift_e, vsel_e, state_e enums, and flag bit indices Z_BIT=2, N_BIT=1, V_BIT=0.
- One sub-module: dp_regfile #(DATA_W, NREGS), one synchronous write port and two combinational read ports (operand, debug).
- Shifter and ALU are inline in datapath_seq.

Test Plan:
- Reset then vsel=01, imm8=8'h85, rd=3, wen=1 → done 1 cycle after accept; dbg R3 = 16'hFF85; flags = 000.
- R1=16'h7FFF, R2=1, ADD rn=1 rm=2 rd=4 loads=1 → done 4th cycle; R4 = 16'h8000; flags = 011; req_ready low 4 cycles.
- SUB R1−R1, loads=1, wen=0 → result = 0; flags = 100; no register write.
- R2=16'h8001, shift=ASR1, MVN → result = 16'h3FFF; shift=LSL1 → result = 16'hFFFD.
- req_valid held high back-to-back with mixed ALU/non-ALU requests → each accepted only when req_ready = 1; one done per request, in order.
- rst_n asserted during EXE → no write; flags unchanged at 0; IDLE with req_ready = 1 after deassert.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types for the sequenced datapath: opcode, shift and writeback-source
// encodings, sequencer states and status flag bit positions.
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VS_MDATA = 2'b00,
    VS_IMM8  = 2'b01,
    VS_PC    = 2'b10,
    VS_ALU   = 2'b11
  } vsel_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXE  = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // Bit positions inside the 3-bit {Z, N, V} flags vector.
  localparam int Z_BIT = 2;
  localparam int N_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/dp_regfile.sv
// General register file: one synchronous write port, one combinational operand
// read port and one combinational debug read port. A read of the register being
// written in the same cycle returns the old contents (no bypass).
module dp_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Register storage: cleared on reset, written on the edge when we is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata    = regs_q[raddr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/datapath_seq.sv
// Parametrised datapath (register file, A/B/C operand registers, shifter, ALU,
// status flags) driven by an internal micro-sequencer. A controller hands over
// one whole instruction through a valid/ready request port and gets a one-cycle
// done pulse when it completes.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only while the sequencer is IDLE; req_* fields, mdata and pc
// are captured at that edge and ignored at all other times.
module datapath_seq
  import dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int PC_W    = 9,
  parameter int IMM5_W  = 5,
  parameter int IMM8_W  = 8,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RA_W-1:0]   req_rn,
  input  logic [RA_W-1:0]   req_rm,
  input  logic [RA_W-1:0]   req_rd,
  input  logic [1:0]        req_aluop,
  input  logic [1:0]        req_shift,
  input  logic              req_asel,
  input  logic              req_bsel,
  input  logic [1:0]        req_vsel,
  input  logic              req_wen,
  input  logic              req_loads,
  input  logic [IMM5_W-1:0] req_imm5,
  input  logic [IMM8_W-1:0] req_imm8,
  input  logic [DATA_W-1:0] mdata,
  input  logic [PC_W-1:0]   pc,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags,
  input  logic [RA_W-1:0]   dbg_rnum,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int MSB = DATA_W - 1;

  // Sequencer state and registered handshake outputs.
  state_e            state_q;
  logic              ready_q;
  logic              done_q;

  // Captured request.
  logic [RA_W-1:0]   rn_q, rm_q, rd_q;
  aluop_e            aluop_q;
  shift_e            shift_q;
  vsel_e             vsel_q;
  logic              asel_q, bsel_q, wen_q, loads_q;
  logic [IMM5_W-1:0] imm5_q;
  logic [IMM8_W-1:0] imm8_q;
  logic [DATA_W-1:0] mdata_q;
  logic [PC_W-1:0]   pc_q;

  // Operand / result registers.
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [2:0]        flags_q;

  // Combinational datapath nets.
  logic [DATA_W-1:0] rf_rdata;
  logic [RA_W-1:0]   rf_raddr;
  logic              rf_we;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] ain, bin;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        alu_flags;

  // The single operand port reads rn during RDA and rm during RDB.
  assign rf_raddr = (state_q == ST_RDB) ? rm_q : rn_q;
  assign rf_we    = (state_q == ST_WB) && wen_q;

  dp_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (wb_data),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (dbg_rnum),
    .dbg_data (dbg_rdata)
  );

  // One-bit shifter on the B register.
  always_comb begin
    b_sh = b_q;
    case (shift_q)
      SH_LSL1: b_sh = {b_q[MSB-1:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_q[MSB:1]};
      SH_ASR1: b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase
  end

  assign ain = asel_q ? '0 : a_q;
  assign bin = bsel_q ? DATA_W'($signed(imm5_q)) : b_sh;

  // ALU with two's-complement overflow detection for ADD/SUB.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (aluop_q)
      ALU_ADD: begin
        alu_res          = ain + bin;
        alu_flags[V_BIT] = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      ALU_SUB: begin
        alu_res          = ain - bin;
        alu_flags[V_BIT] = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      ALU_AND: alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
    alu_flags[Z_BIT] = (alu_res == '0);
    alu_flags[N_BIT] = alu_res[MSB];
  end

  // Writeback source mux; the ALU path writes the C register.
  always_comb begin
    wb_data = c_q;
    case (vsel_q)
      VS_MDATA: wb_data = mdata_q;
      VS_IMM8:  wb_data = DATA_W'($signed(imm8_q));
      VS_PC:    wb_data = DATA_W'(pc_q);
      default:  wb_data = c_q;
    endcase
  end

  // Micro-sequencer: request capture, operand loads, execute and writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      aluop_q <= ALU_ADD;
      shift_q <= SH_NONE;
      vsel_q  <= VS_MDATA;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      wen_q   <= 1'b0;
      loads_q <= 1'b0;
      imm5_q  <= '0;
      imm8_q  <= '0;
      mdata_q <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rn_q    <= req_rn;
            rm_q    <= req_rm;
            rd_q    <= req_rd;
            aluop_q <= aluop_e'(req_aluop);
            shift_q <= shift_e'(req_shift);
            vsel_q  <= vsel_e'(req_vsel);
            asel_q  <= req_asel;
            bsel_q  <= req_bsel;
            wen_q   <= req_wen;
            loads_q <= req_loads;
            imm5_q  <= req_imm5;
            imm8_q  <= req_imm8;
            mdata_q <= mdata;
            pc_q    <= pc;
            ready_q <= 1'b0;
            if (vsel_e'(req_vsel) == VS_ALU) begin
              state_q <= ST_RDA;
            end else begin
              state_q <= ST_WB;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RDA: begin
          a_q     <= rf_rdata;
          state_q <= ST_RDB;
        end
        ST_RDB: begin
          b_q     <= rf_rdata;
          state_q <= ST_EXE;
        end
        ST_EXE: begin
          c_q <= alu_res;
          if (loads_q) begin
            flags_q <= alu_flags;
          end
          state_q <= ST_WB;
          done_q  <= 1'b1;
        end
        ST_WB: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign result    = c_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: a table of directed instructions with hand-computed
// results, plus hand-written sequences for writeback timing, back-to-back
// requests and reset in the middle of an instruction.
module tb_datapath_seq;
  import dp_pkg::*;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_rn = '0, req_rm = '0, req_rd = '0;
  logic [1:0]    req_aluop = '0, req_shift = '0, req_vsel = '0;
  logic          req_asel = 1'b0, req_bsel = 1'b0, req_wen = 1'b0, req_loads = 1'b0;
  logic [4:0]    req_imm5 = '0;
  logic [7:0]    req_imm8 = '0;
  logic [DW-1:0] mdata = '0;
  logic [PW-1:0] pc = '0;
  logic          done;
  logic [DW-1:0] result;
  logic [2:0]    flags;
  logic [2:0]    dbg_rnum = '0;
  logic [DW-1:0] dbg_rdata;

  datapath_seq #(.DATA_W(DW), .NREGS(NR), .PC_W(PW), .IMM5_W(5), .IMM8_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_aluop(req_aluop),
    .req_shift(req_shift), .req_asel(req_asel), .req_bsel(req_bsel),
    .req_vsel(req_vsel), .req_wen(req_wen), .req_loads(req_loads),
    .req_imm5(req_imm5), .req_imm8(req_imm8), .mdata(mdata), .pc(pc),
    .done(done), .result(result), .flags(flags),
    .dbg_rnum(dbg_rnum), .dbg_rdata(dbg_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [2:0]    exp_rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] vsel, aluop, shift;
    logic       asel, bsel, wen, loads;
    logic [2:0] rn, rm, rd;
    logic [4:0] imm5;
    logic [7:0] imm8;
    logic [15:0] mdata;
    logic [8:0]  pc;
    int          lat;
    logic [15:0] exp_reg, exp_res;
    logic [2:0]  exp_flags;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [1:0] vsel, aluop, shift,
                              input logic asel, bsel, wen, loads,
                              input logic [2:0] rn, rm, rd, input logic [4:0] imm5,
                              input logic [7:0] imm8, input logic [15:0] md,
                              input logic [8:0] pcv, input logic [15:0] exp_reg,
                              input logic [15:0] exp_res, input logic [2:0] exp_flags);
    vec_t v;
    v.name = nm; v.vsel = vsel; v.aluop = aluop; v.shift = shift;
    v.asel = asel; v.bsel = bsel; v.wen = wen; v.loads = loads;
    v.rn = rn; v.rm = rm; v.rd = rd; v.imm5 = imm5; v.imm8 = imm8;
    v.mdata = md; v.pc = pcv;
    v.lat = (vsel == 2'b11) ? 4 : 1;
    v.exp_reg = exp_reg; v.exp_res = exp_res; v.exp_flags = exp_flags;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    req_vsel = v.vsel; req_aluop = v.aluop; req_shift = v.shift;
    req_asel = v.asel; req_bsel = v.bsel; req_wen = v.wen; req_loads = v.loads;
    req_rn = v.rn; req_rm = v.rm; req_rd = v.rd;
    req_imm5 = v.imm5; req_imm8 = v.imm8; mdata = v.mdata; pc = v.pc;
  endtask

  // Junk on the request fields while req_valid is low must be ignored.
  task automatic scramble();
    req_vsel = 2'($urandom_range(0, 3)); req_aluop = 2'($urandom_range(0, 3));
    req_shift = 2'($urandom_range(0, 3)); req_rn = 3'($urandom_range(0, 7));
    req_rm = 3'($urandom_range(0, 7)); req_rd = 3'($urandom_range(0, 7));
    req_wen = 1'($urandom_range(0, 1)); req_loads = 1'($urandom_range(0, 1));
    req_asel = 1'($urandom_range(0, 1)); req_bsel = 1'($urandom_range(0, 1));
    req_imm5 = 5'($urandom_range(0, 31)); req_imm8 = 8'($urandom_range(0, 255));
    mdata = 16'($urandom_range(0, 65535)); pc = 9'($urandom_range(0, 511));
  endtask

  // Issue one instruction, measure done latency and ready-low cycles, then
  // check the destination register, C and flags once the write has landed.
  task automatic run_vec(input vec_t v);
    int lat, rdy_low, w;
    @(negedge clk);
    drive(v);
    dbg_rnum  = v.rd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({v.name, "_ready"}, {31'd0, req_ready}, 32'd1);
    exp_q.push_back(v.exp_reg);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble();
    lat = 0;
    rdy_low = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!req_ready) rdy_low++;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({v.name, "_latency"}, lat, v.lat);
    check({v.name, "_ready_low"}, rdy_low, v.lat);
    @(negedge clk);
    check({v.name, "_reg"}, dbg_rdata, exp_q.pop_front());
    check({v.name, "_result"}, result, v.exp_res);
    check({v.name, "_flags"}, flags, v.exp_flags);
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[12];
  vec_t b2b[4];
  vec_t v;
  int   idx, n_done, done_pulses;
  bit   pend, acc;
  logic [15:0] pexp;

  initial begin
    //                 name            vsel   aluop  shift  as bs we ld rn rm rd imm5   imm8   mdata     pc      R[rd]     C         flags
    tbl[0]  = mk("imm8_r3",      2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 3, 5'h00, 8'h85, 16'h0000, 9'h000, 16'hFF85, 16'h0000, 3'b000);
    tbl[1]  = mk("ld_r1",        2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 1, 5'h00, 8'h00, 16'h7FFF, 9'h000, 16'h7FFF, 16'h0000, 3'b000);
    tbl[2]  = mk("ld_r2",        2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2, 5'h00, 8'h00, 16'h0001, 9'h000, 16'h0001, 16'h0000, 3'b000);
    tbl[3]  = mk("add_ovf",      2'b11, 2'b00, 2'b00, 0, 0, 1, 1, 1, 2, 4, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h8000, 16'h8000, 3'b011);
    tbl[4]  = mk("sub_self_nw",  2'b11, 2'b01, 2'b00, 0, 0, 0, 1, 1, 1, 5, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h0000, 16'h0000, 3'b100);
    tbl[5]  = mk("ld_r2b",       2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2, 5'h00, 8'h00, 16'h8001, 9'h000, 16'h8001, 16'h0000, 3'b100);
    tbl[6]  = mk("mvn_asr",      2'b11, 2'b11, 2'b11, 0, 0, 1, 0, 0, 2, 6, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h3FFF, 16'h3FFF, 3'b100);
    tbl[7]  = mk("mvn_lsl",      2'b11, 2'b11, 2'b01, 0, 0, 1, 1, 0, 2, 7, 5'h00, 8'h00, 16'h0000, 9'h000, 16'hFFFD, 16'hFFFD, 3'b010);
    tbl[8]  = mk("pc_r0",        2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 5'h00, 8'h00, 16'h0000, 9'h1AB, 16'h01AB, 16'hFFFD, 3'b010);
    tbl[9]  = mk("imm5_add",     2'b11, 2'b00, 2'b00, 1, 1, 1, 1, 3, 0, 0, 5'h13, 8'h00, 16'h0000, 9'h000, 16'hFFF3, 16'hFFF3, 3'b010);
    tbl[10] = mk("sub_rd_eq_rn", 2'b11, 2'b01, 2'b00, 0, 0, 1, 1, 1, 4, 1, 5'h00, 8'h00, 16'h0000, 9'h000, 16'hFFFF, 16'hFFFF, 3'b011);
    tbl[11] = mk("and_lsr",      2'b11, 2'b10, 2'b10, 0, 0, 1, 1, 3, 7, 2, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h7F84, 16'h7F84, 3'b000);

    // Back-to-back mix: R5=0x11; R6=R5+R5; R7=0xBEEF; R5=~R7.
    b2b[0] = mk("b2b0", 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 5, 5'h00, 8'h11, 16'h0000, 9'h000, 16'h0011, 16'h0000, 3'b000);
    b2b[1] = mk("b2b1", 2'b11, 2'b00, 2'b00, 0, 0, 1, 0, 5, 5, 6, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h0022, 16'h0000, 3'b000);
    b2b[2] = mk("b2b2", 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 7, 5'h00, 8'h00, 16'hBEEF, 9'h000, 16'hBEEF, 16'h0000, 3'b000);
    b2b[3] = mk("b2b3", 2'b11, 2'b11, 2'b00, 0, 0, 1, 0, 0, 7, 5, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h4110, 16'h0000, 3'b000);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", flags, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    for (int r = 0; r < NR; r++) begin
      dbg_rnum = 3'(r);
      #1;
      check("rst_reg", dbg_rdata, 32'd0);
    end

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i]);
    end

    // Writeback timing: old value visible during WB, new value one cycle later.
    @(negedge clk);
    v = mk("wb_old", 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 5, 5'h00, 8'h42, 16'h0000, 9'h000, 16'h0042, 16'h0000, 3'b000);
    drive(v);
    dbg_rnum  = 3'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("wb_done", {31'd0, done}, 32'd1);
    check("wb_old_value", dbg_rdata, 32'h0000);
    @(negedge clk);
    check("wb_new_value", dbg_rdata, 32'h0042);

    // Back-to-back requests with req_valid held high.
    @(negedge clk);
    idx = 0; n_done = 0; pend = 1'b0; pexp = '0;
    drive(b2b[0]);
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && n_done < 4; cyc++) begin
      if (pend) begin
        check("b2b_write", dbg_rdata, pexp);
        pend = 1'b0;
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("b2b_extra_done", 32'd1, 32'd0);
        end else begin
          pexp     = exp_q.pop_front();
          dbg_rnum = exp_rd_q.pop_front();
          pend     = 1'b1;
        end
      end
      acc = req_valid && req_ready;
      if (acc) begin
        exp_q.push_back(b2b[idx].exp_reg);
        exp_rd_q.push_back(b2b[idx].rd);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive(b2b[idx]);
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    if (pend) check("b2b_write", dbg_rdata, pexp);
    check("b2b_done_count", n_done, 32'd4);
    check("b2b_accept_count", idx, 32'd4);
    req_valid = 1'b0;

    // Reset during EXE: aborts with no write and no done pulse.
    @(negedge clk);
    v = mk("rst_exe", 2'b11, 2'b00, 2'b00, 0, 0, 1, 1, 6, 6, 3, 5'h00, 8'h00, 16'h0000, 9'h000, 16'h0000, 16'h0000, 3'b000);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstexe_done", {31'd0, done}, 32'd0);
    check("rstexe_result", result, 32'd0);
    check("rstexe_flags", flags, 32'd0);
    done_pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_pulses++;
    end
    check("rstexe_no_done", done_pulses, 32'd0);
    check("rstexe_ready", {31'd0, req_ready}, 32'd1);
    check("rstexe_flags_after", flags, 32'd0);
    dbg_rnum = 3'd3;
    #1;
    check("rstexe_r3", dbg_rdata, 32'd0);

    // Datapath still works after the abort.
    run_vec(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
